// File: rtl/mips8_ctrl_pkg.sv
// Shared control definitions for the MIPS8 run sequencer: state encoding,
// instruction class codes and the default memory timeout.
package mips8_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } state_e;

    localparam logic [1:0] OPC_ALU   = 2'b00;
    localparam logic [1:0] OPC_LOAD  = 2'b01;
    localparam logic [1:0] OPC_STORE = 2'b10;
    localparam logic [1:0] OPC_HALT  = 2'b11;

    localparam int unsigned MEM_TIMEOUT_DEF = 8;

    typedef struct packed {
        logic mem_req;
        logic mem_we;
        logic ir_load;
        logic pc_inc;
        logic alu_en;
        logic reg_we;
        logic busy;
        logic stopped;
        logic fault;
    } ctrl_out_t;

    // Moore decode; evaluated on the next state so the outputs can be registered.
    function automatic ctrl_out_t decode_ctrl(input state_e st, input logic [1:0] cls);
        ctrl_out_t c;
        c = '0;
        case (st)
            ST_FETCH: begin
                c.mem_req = 1'b1;
                c.busy    = 1'b1;
            end
            ST_DECODE: begin
                c.ir_load = 1'b1;
                c.pc_inc  = 1'b1;
                c.busy    = 1'b1;
            end
            ST_EXEC: begin
                c.alu_en = 1'b1;
                c.busy   = 1'b1;
            end
            ST_MEM: begin
                c.mem_req = 1'b1;
                c.mem_we  = (cls == OPC_STORE);
                c.busy    = 1'b1;
            end
            ST_WB: begin
                c.reg_we = 1'b1;
                c.busy   = 1'b1;
            end
            ST_HALT: begin
                c.stopped = 1'b1;
            end
            ST_FAULT: begin
                c.stopped = 1'b1;
                c.fault   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_run_sequencer_if.sv
// Run/stop, decode and memory-port handshake signals between the sequencer
// and the datapath/run-control side.
interface cpu_run_sequencer_if #(
    parameter int CYCLE_W = 16
);
    logic               start;
    logic [1:0]         op_class;
    logic               mem_ack;
    logic               mem_req;
    logic               mem_we;
    logic               ir_load;
    logic               pc_inc;
    logic               alu_en;
    logic               reg_we;
    logic               busy;
    logic               stopped;
    logic               fault;
    logic [CYCLE_W-1:0] cycle_count;

    modport master (
        input  start, op_class, mem_ack,
        output mem_req, mem_we, ir_load, pc_inc, alu_en, reg_we,
               busy, stopped, fault, cycle_count
    );

    modport slave (
        output start, op_class, mem_ack,
        input  mem_req, mem_we, ir_load, pc_inc, alu_en, reg_we,
               busy, stopped, fault, cycle_count
    );
endinterface

// File: rtl/cpu_run_sequencer_mem_wait_timer.sv
// Counts consecutive un-acknowledged memory cycles and flags the cycle in
// which the timeout completes.
module mem_wait_timer
    import mips8_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ack,
    output logic expired
);

    logic [7:0] wait_q;
    logic [7:0] wait_d;

    // An ack in the final cycle suppresses expiry, so the normal transition wins.
    always_comb begin
        expired = active && !ack && (wait_q == 8'(MEM_TIMEOUT - 1));
        wait_d  = '0;
        if (active && !ack && !expired) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

endmodule

// File: rtl/cpu_run_sequencer.sv
// Multi-cycle MIPS8 control sequencer: fetch/decode/exec/mem/wb stepping,
// memory handshake with timeout, halt/fault stop and busy-cycle counter.
module cpu_run_sequencer
    import mips8_ctrl_pkg::*;
#(
    parameter int          CYCLE_W     = 16,
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cpu_run_sequencer_if.master  bus
);

    state_e             state_q, state_d;
    logic [1:0]         cls_q, cls_d;
    logic [CYCLE_W-1:0] cycle_count_q, cycle_count_d;
    ctrl_out_t          ctrl_q, ctrl_d;
    logic               wait_active;
    logic               wait_expired;

    assign wait_active = (state_q == ST_FETCH) || (state_q == ST_MEM);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (wait_active),
        .ack     (bus.mem_ack),
        .expired (wait_expired)
    );

    always_comb begin
        state_d       = state_q;
        cls_d         = cls_q;
        cycle_count_d = cycle_count_q;

        if (ctrl_q.busy && (cycle_count_q != '1)) begin
            cycle_count_d = cycle_count_q + CYCLE_W'(1);
        end

        case (state_q)
            ST_IDLE, ST_HALT, ST_FAULT: begin
                if (bus.start) begin
                    state_d       = ST_FETCH;
                    cycle_count_d = '0;
                end
            end
            ST_FETCH: begin
                if (wait_expired) begin
                    state_d = ST_FAULT;
                end else if (bus.mem_ack) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                cls_d   = bus.op_class;
                state_d = (bus.op_class == OPC_HALT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                state_d = (cls_q == OPC_LOAD || cls_q == OPC_STORE) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (wait_expired) begin
                    state_d = ST_FAULT;
                end else if (bus.mem_ack) begin
                    state_d = (cls_q == OPC_LOAD) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase

        ctrl_d = decode_ctrl(state_d, cls_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cls_q         <= OPC_ALU;
            cycle_count_q <= '0;
            ctrl_q        <= '0;
        end else begin
            state_q       <= state_d;
            cls_q         <= cls_d;
            cycle_count_q <= cycle_count_d;
            ctrl_q        <= ctrl_d;
        end
    end

    assign bus.mem_req     = ctrl_q.mem_req;
    assign bus.mem_we      = ctrl_q.mem_we;
    assign bus.ir_load     = ctrl_q.ir_load;
    assign bus.pc_inc      = ctrl_q.pc_inc;
    assign bus.alu_en      = ctrl_q.alu_en;
    assign bus.reg_we      = ctrl_q.reg_we;
    assign bus.busy        = ctrl_q.busy;
    assign bus.stopped     = ctrl_q.stopped;
    assign bus.fault       = ctrl_q.fault;
    assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Self-checking bench for cpu_run_sequencer: cycle vector table through a
// scoreboard queue, plus async-reset and counter-saturation sequences.
module tb_cpu_run_sequencer;
    import mips8_ctrl_pkg::*;

    // Output bit order: {mem_req, mem_we, ir_load, pc_inc, alu_en, reg_we, busy, stopped, fault}
    localparam logic [8:0] O_I  = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] O_F  = 9'b1_0_0_0_0_0_1_0_0;
    localparam logic [8:0] O_D  = 9'b0_0_1_1_0_0_1_0_0;
    localparam logic [8:0] O_E  = 9'b0_0_0_0_1_0_1_0_0;
    localparam logic [8:0] O_ML = 9'b1_0_0_0_0_0_1_0_0;
    localparam logic [8:0] O_MS = 9'b1_1_0_0_0_0_1_0_0;
    localparam logic [8:0] O_W  = 9'b0_0_0_0_0_1_1_0_0;
    localparam logic [8:0] O_H  = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] O_X  = 9'b0_0_0_0_0_0_0_1_1;

    typedef struct {
        logic        start;
        logic [1:0]  op;
        logic        ack;
        logic [8:0]  exp_out;
        logic [15:0] exp_cnt;
    } vec_t;

    typedef struct {
        logic [8:0]  out;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;
    vec_t vecs[$];
    exp_t sb[$];

    cpu_run_sequencer_if #(.CYCLE_W(16)) bus ();
    cpu_run_sequencer_if #(.CYCLE_W(3))  bus3 ();

    cpu_run_sequencer #(.CYCLE_W(16), .MEM_TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    cpu_run_sequencer #(.CYCLE_W(3), .MEM_TIMEOUT(8)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] outs();
        return {bus.mem_req, bus.mem_we, bus.ir_load, bus.pc_inc, bus.alu_en,
                bus.reg_we, bus.busy, bus.stopped, bus.fault};
    endfunction

    task automatic add(input logic s, input logic [1:0] op, input logic ack,
                       input logic [8:0] o, input int c);
        vec_t v;
        v.start = s; v.op = op; v.ack = ack; v.exp_out = o; v.exp_cnt = 16'(c);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic step(input string name, input logic s, input logic [1:0] op,
                        input logic ack, input logic [8:0] o, input int c);
        exp_t e;
        bus.start = s; bus.op_class = op; bus.mem_ack = ack;
        e.out = o; e.cnt = 16'(c);
        sb.push_back(e);
        @(posedge clk);
        #1;
        tests++;
        if (sb.size() == 0) begin
            failed++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            if (outs() !== e.out || bus.cycle_count !== e.cnt) begin
                failed++;
                $display("FAIL %s: out=%b cnt=%0d, expected out=%b cnt=%0d",
                         name, outs(), bus.cycle_count, e.out, e.cnt);
            end
        end
    endtask

    initial begin
        tests = 0; failed = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op_class = OPC_ALU; bus.mem_ack = 1'b0;
        bus3.start = 1'b0; bus3.op_class = OPC_ALU; bus3.mem_ack = 1'b1;

        // Two ALU instructions, ack tied high.
        add(1, OPC_ALU, 1, O_F, 0);
        add(0, OPC_ALU, 1, O_D, 1); add(0, OPC_ALU, 1, O_E, 2);
        add(0, OPC_ALU, 1, O_W, 3); add(0, OPC_ALU, 1, O_F, 4);
        add(0, OPC_ALU, 1, O_D, 5); add(0, OPC_ALU, 1, O_E, 6);
        add(0, OPC_ALU, 1, O_W, 7); add(0, OPC_ALU, 1, O_F, 8);
        // LOAD with two MEM wait cycles.
        add(0, OPC_LOAD, 1, O_D, 9);   add(0, OPC_LOAD, 1, O_E, 10);
        add(0, OPC_LOAD, 0, O_ML, 11); add(0, OPC_LOAD, 0, O_ML, 12);
        add(0, OPC_LOAD, 0, O_ML, 13); add(0, OPC_LOAD, 1, O_W, 14);
        add(0, OPC_LOAD, 1, O_F, 15);
        // STORE, ack immediate.
        add(0, OPC_STORE, 1, O_D, 16); add(0, OPC_STORE, 1, O_E, 17);
        add(0, OPC_STORE, 1, O_MS, 18); add(0, OPC_STORE, 1, O_F, 19);
        // Ack arriving in the final allowed FETCH cycle wins over the timeout.
        for (int k = 0; k < 7; k++) add(0, OPC_ALU, 0, O_F, 20 + k);
        add(0, OPC_ALU, 1, O_D, 27); add(0, OPC_ALU, 1, O_E, 28);
        add(0, OPC_ALU, 1, O_W, 29); add(0, OPC_ALU, 1, O_F, 30);
        // FETCH timeout after exactly 8 no-ack cycles, then restart.
        for (int k = 0; k < 7; k++) add(0, OPC_ALU, 0, O_F, 31 + k);
        add(0, OPC_ALU, 0, O_X, 38); add(0, OPC_ALU, 1, O_X, 38);
        add(1, OPC_ALU, 1, O_F, 0);
        // HALT: stopped two clocks after FETCH entry, count frozen, restart.
        add(0, OPC_HALT, 1, O_D, 1); add(0, OPC_HALT, 1, O_H, 2);
        add(0, OPC_HALT, 1, O_H, 2); add(1, OPC_ALU, 1, O_F, 0);
        // start while busy is ignored.
        add(1, OPC_ALU, 1, O_D, 1); add(1, OPC_ALU, 1, O_E, 2);
        add(0, OPC_ALU, 1, O_W, 3); add(0, OPC_ALU, 1, O_F, 4);

        @(negedge clk);
        chk("reset_outs", int'(outs()), int'(O_I));
        chk("reset_cnt", int'(bus.cycle_count), 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].start, vecs[i].op, vecs[i].ack,
                 vecs[i].exp_out, int'(vecs[i].exp_cnt));
        end

        // Async reset while a STORE is in MEM.
        step("st_d", 0, OPC_STORE, 1, O_D, 5);
        step("st_e", 0, OPC_STORE, 1, O_E, 6);
        step("st_m", 0, OPC_STORE, 1, O_MS, 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_req", int'(bus.mem_req), 0);
        chk("arst_mem_we", int'(bus.mem_we), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_outs", int'(outs()), int'(O_I));
        chk("arst_cnt", int'(bus.cycle_count), 0);
        step("arst_hold", 0, OPC_ALU, 1, O_I, 0);
        rst_n = 1'b1;
        step("idle0", 0, OPC_ALU, 1, O_I, 0);
        step("idle1", 0, OPC_ALU, 1, O_I, 0);
        step("restart", 1, OPC_ALU, 1, O_F, 0);
        bus.start = 1'b0;

        // 3-bit counter saturates at 7 in a continuous ALU loop.
        bus3.start = 1'b1;
        @(posedge clk); #1;
        bus3.start = 1'b0;
        chk("sat_start", int'(bus3.cycle_count), 0);
        for (int k = 0; k < 3; k++) @(posedge clk);
        #1;
        chk("sat_3", int'(bus3.cycle_count), 3);
        for (int k = 0; k < 4; k++) @(posedge clk);
        #1;
        chk("sat_7", int'(bus3.cycle_count), 7);
        for (int k = 0; k < 6; k++) @(posedge clk);
        #1;
        chk("sat_hold", int'(bus3.cycle_count), 7);
        chk("sat_busy", int'(bus3.busy), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/cpu_run_sequencer.md
Name: cpu_run_sequencer

Overview:
Multi-cycle control sequencer for the MIPS8 CPU. It sits between the top-level run/stop interface and the datapath. After a start request it steps each instruction through fetch, decode, execute, memory and writeback phases, and handshakes with the shared instruction/data memory port. It reports stopped after a HALT instruction or a memory fault, and keeps a run-cycle count for debug.

Parameters:
CYCLE_W, 16, width of cycle_count
MEM_TIMEOUT, 8, consecutive no-ack cycles tolerated in FETCH/MEM before fault; legal range 1..255

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  run request, sampled on clk; acted on only in IDLE, HALT or FAULT
op_class  in  2  decoded instruction class, valid in DECODE: 00 ALU, 01 LOAD, 10 STORE, 11 HALT
mem_ack  in  1  memory port completion; counted only in FETCH/MEM
mem_req  out  1  memory access request
mem_we  out  1  write strobe qualifier for mem_req
ir_load  out  1  load instruction register
pc_inc  out  1  increment PC
alu_en  out  1  ALU result register enable
reg_we  out  1  register file write enable
busy  out  1  instruction in progress
stopped  out  1  CPU halted or faulted
fault  out  1  memory timeout occurred
cycle_count  out  CYCLE_W  clocks spent busy since last start

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT. Reset forces IDLE.
- Reset values: all outputs 0; cycle_count 0; latched class 00; wait counter 0.
- Outputs are a Moore decode of the registered state.
  - mem_req is 1 in FETCH and MEM.
  - mem_we is 1 only in MEM with latched class STORE.
  - ir_load and pc_inc are 1 in DECODE.
  - alu_en is 1 in EXEC; reg_we is 1 in WB.
  - busy is 1 in FETCH..WB.
  - stopped is 1 in HALT and FAULT; fault is 1 in FAULT only.
- Transitions:
  - IDLE, HALT or FAULT with start=1 -> FETCH. The same edge clears cycle_count and the wait counter.
  - FETCH: mem_ack=1 -> DECODE; otherwise stay.
  - DECODE: latch op_class. ALU/LOAD/STORE -> EXEC; HALT -> HALT.
  - EXEC: LOAD/STORE -> MEM; ALU -> WB.
  - MEM: mem_ack=1 -> WB for LOAD, -> FETCH for STORE; otherwise stay.
  - WB -> FETCH.
- Latency with mem_ack high on the first request cycle:
  - ALU 4 clocks (F, D, E, W).
  - LOAD 5 clocks (F, D, E, M, W).
  - STORE 4 clocks (F, D, E, M).
  - HALT reaches HALT 2 clocks after entering FETCH.
  - Each wait cycle adds 1 clock.
- Timeout:
  - The wait counter increments on each FETCH/MEM cycle with mem_ack=0 and clears on ack or on state change.
  - When MEM_TIMEOUT consecutive no-ack cycles complete, the next edge enters FAULT.
  - mem_ack=1 in that final cycle wins: the normal transition is taken, no fault.
- cycle_count increments on every edge where busy=1 and saturates at all-ones (no wrap).
  - It holds its value in HALT and FAULT so software can read the run length.
- start while busy is ignored; it is not queued.
- mem_ack outside FETCH/MEM is ignored.
- op_class outside DECODE is don't-care.
- rst_n low mid-instruction: all outputs drop to 0 asynchronously, with no partial reg_we or mem_we. After release the sequencer sits in IDLE until start.

Decomposition:
- Shared package mips8_ctrl_pkg holds:
  - the state enumeration (3-bit encoding);
  - op_class constants OPC_ALU, OPC_LOAD, OPC_STORE, OPC_HALT;
  - the default MEM_TIMEOUT.
  The decoder and bench share it.
- One sub-module, mem_wait_timer, contains the wait counter and the timeout compare. Its ports are clk, rst_n, active, ack and expired.

Test Plan:
1. Reset then start pulse, op_class=ALU, mem_ack tied 1. Expected: FETCH, DECODE, EXEC, WB repeating every 4 clocks. reg_we pulses once per 4 clocks; cycle_count=8 after two instructions.
2. LOAD with mem_ack low for 2 MEM cycles. Expected: mem_req high 3 clocks in MEM, mem_we=0. reg_we follows 1 clock after ack; instruction takes 7 clocks.
3. STORE with mem_ack=1. Expected: mem_we=1 only in the MEM cycle, reg_we never asserts, next FETCH right after MEM.
4. mem_ack held 0 in FETCH, MEM_TIMEOUT=8. Expected: FAULT after exactly 8 FETCH cycles with fault=1, stopped=1, busy=0. Then a start pulse returns to FETCH with fault=0 and cycle_count=0.
5. op_class=HALT. Expected: stopped=1 two clocks after FETCH entry; cycle_count frozen at 2; start restarts.
6. rst_n asserted during MEM of a STORE. Expected: mem_req, mem_we, busy and cycle_count are 0 immediately; with CYCLE_W=3 and an ALU loop, cycle_count saturates at 7.
